// File: rtl/serial_parallel_mult.sv
// Serial-parallel carry-save multiplier: captures a/b on start, emits the product LSB first and as a word.
// Latency: first bit_valid 1 cycle after accept, done 2*WIDTH cycles after accept; back-to-back starts allowed.
// Backpressure: none; start is ignored while busy and abort cancels a run with no done pulse.
module serial_parallel_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CNT_W = $clog2(2 * WIDTH);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(2 * WIDTH - 1);
    localparam logic [CNT_W-1:0] MULT_K = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sum_q;
    logic [WIDTH-1:0]     carry_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 bit_q;
    logic                 bvld_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 done_q;

    logic                 m;
    logic [WIDTH-1:0]     pp;
    logic [WIDTH-1:0]     sum_in;
    logic [WIDTH-1:0]     sum_d;
    logic [WIDTH-1:0]     carry_d;

    // Row of full adders: sums ripple one cell toward bit 0 per cycle, carries stay put.
    always_comb begin
        m       = (cnt_q < MULT_K) ? b_q[0] : 1'b0;
        pp      = a_q & {WIDTH{m}};
        sum_in  = {1'b0, sum_q[WIDTH-1:1]};
        sum_d   = pp ^ sum_in ^ carry_q;
        carry_d = (pp & sum_in) | (pp & carry_q) | (sum_in & carry_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            bit_q   <= 1'b0;
            bvld_q  <= 1'b0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bvld_q <= 1'b0;
                    if (start && !abort) begin
                        a_q     <= a;
                        b_q     <= b;
                        sum_q   <= '0;
                        carry_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Product is left mid-shift; only done qualifies it.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        bvld_q  <= 1'b0;
                    end else begin
                        sum_q   <= sum_d;
                        carry_q <= carry_d;
                        b_q     <= b_q >> 1;
                        bit_q   <= sum_d[0];
                        bvld_q  <= 1'b1;
                        prod_q  <= {sum_d[0], prod_q[2*WIDTH-1:1]};
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_K) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    bvld_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign bit_out   = bit_q;
    assign bit_valid = bvld_q;
    assign product   = prod_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_parallel_mult.sv
// Directed bench for serial_parallel_mult: a 16-bit instance for streams, handshake, abort and reset,
// and a 4-bit instance swept over all operand pairs back-to-back.
module tb_serial_parallel_mult;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        bit_out;
    logic        bit_valid;
    logic [31:0] product;
    logic        done;

    logic        s4_start;
    logic [3:0]  s4_a;
    logic [3:0]  s4_b;
    logic        s4_busy;
    logic        s4_bit_out;
    logic        s4_bit_valid;
    logic [7:0]  s4_product;
    logic        s4_done;

    int n_assert;
    int n_fail;

    serial_parallel_mult #(.WIDTH(16)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .product   (product),
        .done      (done)
    );

    serial_parallel_mult #(.WIDTH(4)) u_dut4 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (s4_start),
        .abort     (1'b0),
        .a         (s4_a),
        .b         (s4_b),
        .busy      (s4_busy),
        .bit_out   (s4_bit_out),
        .bit_valid (s4_bit_valid),
        .product   (s4_product),
        .done      (s4_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accepts one operation and follows it to its done cycle. With b2b set the task returns in
    // the done cycle so the caller can present the next start there. ign_k>=0 pulses a stray start mid-run.
    task automatic do_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic [31:0] exp, input bit b2b, input int ign_k);
        logic [31:0] stream;
        int bad_busy;
        int bad_valid;
        int early_done;
        stream = '0;
        bad_busy = 0;
        bad_valid = 0;
        early_done = 0;
        a = ta;
        b = tb;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_on_accept"}, 64'(busy), 64'd1);
        check({tag, "_done_on_accept"}, 64'(done), 64'd0);
        for (int k = 0; k < 32; k++) begin
            if (k == ign_k) begin
                a = 16'hFFFF;
                b = 16'hFFFF;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            stream[k] = bit_out;
            if (bit_valid !== 1'b1) bad_valid++;
            if (k < 31) begin
                if (busy !== 1'b1) bad_busy++;
                if (done !== 1'b0) early_done++;
            end
        end
        check({tag, "_stream"}, 64'(stream), 64'(exp));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_busy_gaps"}, 64'(bad_busy), 64'd0);
        check({tag, "_valid_gaps"}, 64'(bad_valid), 64'd0);
        check({tag, "_early_done"}, 64'(early_done), 64'd0);
        if (!b2b) begin
            step();
            check({tag, "_done_pulse_ends"}, 64'(done), 64'd0);
            check({tag, "_valid_idle"}, 64'(bit_valid), 64'd0);
        end
    endtask

    initial begin
        int stray_done;
        int bad_timing;
        n_assert = 0;
        n_fail = 0;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a = '0;
        b = '0;
        s4_start = 1'b0;
        s4_a = '0;
        s4_b = '0;

        #23;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_outputs", {29'd0, bit_out, bit_valid, done, product}, 64'd0);
        reset_n = 1'b1;
        step();
        check("idle_after_reset", {busy, bit_valid, done}, 64'd0);

        do_mul("t1_3x5", 16'd3, 16'd5, 32'h0000_000F, 1'b0, -1);
        do_mul("t2_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, -1);
        do_mul("t3_zero_a", 16'h0000, 16'hABCD, 32'h0000_0000, 1'b0, -1);
        do_mul("t3_msb", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, -1);
        do_mul("t3_one", 16'h0001, 16'hFFFF, 32'h0000_FFFF, 1'b0, -1);

        do_mul("t4_first", 16'd3, 16'd5, 32'h0000_000F, 1'b1, -1);
        do_mul("t4_second", 16'd7, 16'd9, 32'h0000_003F, 1'b0, 5);

        // Abort at k=10, then nothing may complete.
        a = 16'h1234;
        b = 16'h5678;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_busy", 64'(busy), 64'd0);
        check("t5_abort_valid", 64'(bit_valid), 64'd0);
        stray_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) stray_done++;
            step();
        end
        check("t5_abort_no_done", 64'(stray_done), 64'd0);

        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("t5_abort_beats_start", 64'(busy), 64'd0);

        do_mul("t5_after_abort", 16'h1234, 16'h5678, 32'h0626_0060, 1'b0, -1);

        // Reset pulled at k=20 must clear everything without waiting for an edge.
        a = 16'hFFFF;
        b = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check("t5_busy_before_reset", 64'(busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_reset_outputs", {29'd0, busy, bit_valid, done, product}, 64'd0);
        check("t5_reset_bit", 64'(bit_out), 64'd0);
        #2 reset_n = 1'b1;
        stray_done = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) stray_done++;
        end
        check("t5_reset_no_done", 64'(stray_done), 64'd0);

        // 4-bit sweep, each start presented in the previous done cycle.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [7:0] expv;
                expv = 8'(i) * 8'(j);
                s4_a = 4'(i);
                s4_b = 4'(j);
                s4_start = 1'b1;
                step();
                s4_start = 1'b0;
                bad_timing = 0;
                for (int k = 0; k < 7; k++) begin
                    step();
                    if (s4_done !== 1'b0 || s4_busy !== 1'b1) bad_timing++;
                end
                step();
                if (s4_done !== 1'b1) bad_timing++;
                check($sformatf("t6_prod_%0dx%0d", i, j), 64'(s4_product), 64'(expv));
                check($sformatf("t6_timing_%0dx%0d", i, j), 64'(bad_timing), 64'd0);
            end
        end
        step();
        check("t6_final_idle", {s4_done, s4_busy, s4_bit_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
